// File: rtl/rr_trunc_inc_sched_if.sv
// Request/result bus for rr_trunc_inc_sched.
// master: operand sources and the result consumer. slave: the scheduler.
interface rr_trunc_inc_sched_if #(
  parameter int N  = 4,
  parameter int DW = 6,
  parameter int W  = 3
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_data;
  logic [IDW-1:0]  res_id;
  logic            res_trunc;
  logic            busy;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_trunc, busy
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_data, res_id, res_trunc, busy
  );
endinterface

// File: rtl/rr_trunc_inc_sched.sv
// Round-robin scheduler sharing one W'(d+1) increment-and-truncate unit
// among N requesters. One request is in flight at a time: IDLE grants,
// CALC computes, HOLD presents the result until the consumer takes it.
// Optional build macro SATURATE_EN: clamp the result to all-ones when
// high bits would be lost instead of wrapping modulo 2^W.
module rr_trunc_inc_sched #(
  parameter int N  = 4,
  parameter int DW = 6,
  parameter int W  = 3
) (
  input logic              clk,
  input logic              rst,
  rr_trunc_inc_sched_if.slave bus
);
  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

  state_e         state_q;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q;
  logic [DW-1:0]  op_q;
  logic           res_valid_q;
  logic [W-1:0]   res_data_q, res_data_d;
  logic [IDW-1:0] res_id_q;
  logic           res_trunc_q, res_trunc_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic           hi_found, lo_found;
  logic [IDW-1:0] hi_idx, lo_idx;
  logic [DW:0]    sum;

  // Rotating priority: lowest valid index at or above ptr, else lowest overall.
  // Descending scan so the last hit is the lowest index.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    gnt_found = hi_found | lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
    ptr_d     = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // One-hot accept strobe; suppressed under reset so nothing is consumed then.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && state_q == IDLE && gnt_found)
      bus.req_ready[gnt_idx] = 1'b1;
  end

  assign sum = {1'b0, op_q} + (DW + 1)'(1);

  // Lost-bit detection; nothing can be lost when the result is full width.
  generate
    if (W < DW + 1) begin : g_trunc
      assign res_trunc_d = |sum[DW:W];
    end else begin : g_notrunc
      assign res_trunc_d = 1'b0;
    end
  endgenerate

  // Result value: wrap by default, clamp to all-ones in the saturating build.
  always_comb begin
`ifdef SATURATE_EN
    res_data_d = res_trunc_d ? {W{1'b1}} : sum[W-1:0];
`else
    res_data_d = sum[W-1:0];
`endif
  end

  // Scheduler FSM with registered result outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_trunc_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            op_q    <= bus.req_data[gnt_idx*DW +: DW];
            id_q    <= gnt_idx;
            ptr_q   <= ptr_d;
            state_q <= CALC;
          end
        end
        CALC: begin
          res_data_q  <= res_data_d;
          res_trunc_q <= res_trunc_d;
          res_id_q    <= id_q;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_trunc = res_trunc_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
